// File: rtl/txrx_seq_pkg.sv
// Shared definitions for txrx_seq: register map, CMD/CTRL/IRQ bit indices,
// STATUS field offsets and the 2-bit sequencer state encoding.
package txrx_seq_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned TMO_W  = 24;
  localparam int unsigned IRQ_W  = 4;
  localparam int unsigned CTRL_W = 3;

  // Word addresses
  localparam int unsigned A_CTRL     = 0;
  localparam int unsigned A_CMD      = 1;
  localparam int unsigned A_STATUS   = 2;
  localparam int unsigned A_IRQ_STAT = 3;
  localparam int unsigned A_IRQ_MASK = 4;
  localparam int unsigned A_TX_DATA  = 5;
  localparam int unsigned A_RX_DATA  = 6;
  localparam int unsigned A_AA       = 7;
  localparam int unsigned A_CH_IDX   = 8;
  localparam int unsigned A_RX_TMO   = 9;

  // CTRL bits
  localparam int unsigned CTRL_TX_EN   = 0;
  localparam int unsigned CTRL_RX_EN   = 1;
  localparam int unsigned CTRL_AUTO_RX = 2;

  // CMD bits
  localparam int unsigned CMD_GO_TX = 0;
  localparam int unsigned CMD_GO_RX = 1;
  localparam int unsigned CMD_ABORT = 2;
  localparam int unsigned CMD_FLUSH = 3;

  // IRQ bits
  localparam int unsigned IRQ_TX_DONE = 0;
  localparam int unsigned IRQ_RX_DONE = 1;
  localparam int unsigned IRQ_TMO     = 2;
  localparam int unsigned IRQ_RX_OVF  = 3;

  // STATUS layout, LSB first:
  //   [0] aa_found, [1] crc_valid, [2] rxf_empty, [3] txf_empty, [4] txf_full,
  //   then rxf_cnt (FIFO_AW+1 bits), txf_cnt (FIFO_AW+1 bits), state (2 bits).
  localparam int unsigned ST_RXF_CNT_LSB = 5;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_TX_RUN   = 2'd1,
    ST_IFS_WAIT = 2'd2,
    ST_RX_RUN   = 2'd3
  } state_e;

endpackage

// File: rtl/txrx_fifo.sv
// Synchronous byte FIFO with first-word-fall-through read.
// Ports: clk/rst, clear (synchronous empty), push/wr_data, pop,
//        rd_data_c (head byte), full_c, empty_c, count (registered occupancy).
// Pushes while full and pops while empty are ignored.
module txrx_fifo #(
  parameter int unsigned FIFO_AW = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic               push,
  input  logic [7:0]         wr_data,
  input  logic               pop,
  output logic [7:0]         rd_data_c,
  output logic               full_c,
  output logic               empty_c,
  output logic [FIFO_AW:0]   count
);

  localparam int unsigned DEPTH = 1 << FIFO_AW;

  logic [7:0]         mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr;
  logic [FIFO_AW-1:0] rd_ptr;
  logic               do_push;
  logic               do_pop;

  assign full_c    = (count == (FIFO_AW+1)'(DEPTH));
  assign empty_c   = (count == '0);
  assign do_push   = push & ~full_c;
  assign do_pop    = pop & ~empty_c;
  assign rd_data_c = mem[rd_ptr];

  // Pointer and occupancy tracking
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + FIFO_AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + FIFO_AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (FIFO_AW+1)'(1);
        2'b01:   count <= count - (FIFO_AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage, no reset needed
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/txrx_seq.sv
// CPU-facing TX/RX packet sequencer with byte FIFOs and auto TX->RX turnaround.
// Ports: clk/rst; CPU bus valid/address/wdata/wstrb -> rdata/ready;
//        TX stream tx_byte/tx_byte_valid/tx_byte_ready plus tx_start/tx_en/tx_done;
//        RX stream rx_byte/rx_byte_valid plus rx_start/rx_en/rx_pkt_done/
//        rx_crc_valid/rx_aa_found; shared config aa/ch_idx; level irq.
module txrx_seq
  import txrx_seq_pkg::*;
#(
  parameter int unsigned ADDR_W     = 4,
  parameter int unsigned FIFO_AW    = 5,
  parameter int unsigned CH_IDX_W   = 6,
  parameter int unsigned IFS_CYCLES = 150,
  parameter logic [31:0] AA_RST     = 32'h8E89BED6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                valid,
  input  logic [ADDR_W-1:0]   address,
  input  logic [31:0]         wdata,
  input  logic                wstrb,
  output logic [31:0]         rdata,
  output logic                ready,
  output logic [7:0]          tx_byte,
  output logic                tx_byte_valid,
  input  logic                tx_byte_ready,
  output logic                tx_start,
  output logic                tx_en,
  input  logic                tx_done,
  input  logic [7:0]          rx_byte,
  input  logic                rx_byte_valid,
  output logic                rx_start,
  output logic                rx_en,
  input  logic                rx_pkt_done,
  input  logic                rx_crc_valid,
  input  logic                rx_aa_found,
  output logic [31:0]         aa,
  output logic [CH_IDX_W-1:0] ch_idx,
  output logic                irq
);

  localparam int unsigned CNT_W = FIFO_AW + 1;

  state_e              state_q, state_d;
  logic [TMO_W-1:0]    cnt_q, cnt_d;
  logic                tx_start_d, rx_start_d;
  logic                set_tx_done, set_rx_done, set_tmo, pkt_latch;

  logic [CTRL_W-1:0]   ctrl_q;
  logic [IRQ_W-1:0]    irq_stat_q, irq_stat_d, irq_mask_q, irq_mask_d, irq_set, irq_clr;
  logic [TMO_W-1:0]    rx_tmo_q;
  logic                crc_q, aa_found_q;

  logic                acc, wr_acc, rd_acc;
  logic                cmd_wr, go_tx, go_rx, abort, flush;
  logic [31:0]         rd_mux_c;

  logic [7:0]          txf_data, rxf_data;
  logic                txf_full, txf_empty, rxf_full, rxf_empty;
  logic [CNT_W-1:0]    txf_cnt, rxf_cnt;
  logic                rx_push, rx_pop, tx_push, tx_pop;
  logic                unused_c;

  assign unused_c = ^wdata;

  // One side-effecting cycle per bus access
  assign acc    = valid & ~ready;
  assign wr_acc = acc & wstrb;
  assign rd_acc = acc & ~wstrb;

  assign cmd_wr = wr_acc & (address == ADDR_W'(A_CMD));
  assign go_tx  = cmd_wr & wdata[CMD_GO_TX];
  assign go_rx  = cmd_wr & wdata[CMD_GO_RX];
  assign abort  = cmd_wr & wdata[CMD_ABORT];
  assign flush  = cmd_wr & wdata[CMD_FLUSH];

  assign tx_push = wr_acc & (address == ADDR_W'(A_TX_DATA));
  assign tx_pop  = tx_byte_valid & tx_byte_ready;
  assign rx_push = rx_byte_valid & (state_q == ST_RX_RUN);
  assign rx_pop  = rd_acc & (address == ADDR_W'(A_RX_DATA));

  txrx_fifo #(.FIFO_AW(FIFO_AW)) u_txf (
    .clk(clk), .rst(rst), .clear(flush),
    .push(tx_push), .wr_data(wdata[7:0]), .pop(tx_pop),
    .rd_data_c(txf_data), .full_c(txf_full), .empty_c(txf_empty), .count(txf_cnt)
  );

  txrx_fifo #(.FIFO_AW(FIFO_AW)) u_rxf (
    .clk(clk), .rst(rst), .clear(flush),
    .push(rx_push), .wr_data(rx_byte), .pop(rx_pop),
    .rd_data_c(rxf_data), .full_c(rxf_full), .empty_c(rxf_empty), .count(rxf_cnt)
  );

  assign tx_byte       = txf_data;
  assign tx_byte_valid = ~txf_empty & (state_q == ST_TX_RUN);
  assign tx_en         = ctrl_q[CTRL_TX_EN];
  assign rx_en         = (state_q == ST_RX_RUN) | (ctrl_q[CTRL_RX_EN] & (state_q == ST_IDLE));

  // Sequencer state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      tx_start <= 1'b0;
      rx_start <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      tx_start <= tx_start_d;
      rx_start <= rx_start_d;
    end
  end

  // Sequencer next state; cnt_q times both the IFS gap and the RX timeout
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + TMO_W'(1);
    tx_start_d  = 1'b0;
    rx_start_d  = 1'b0;
    set_tx_done = 1'b0;
    set_rx_done = 1'b0;
    set_tmo     = 1'b0;
    pkt_latch   = 1'b0;
    if (abort) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          cnt_d = '0;
          if (go_tx && ctrl_q[CTRL_TX_EN]) begin
            state_d    = ST_TX_RUN;
            tx_start_d = 1'b1;
          end else if (go_rx && ctrl_q[CTRL_RX_EN]) begin
            state_d    = ST_RX_RUN;
            rx_start_d = 1'b1;
          end
        end
        ST_TX_RUN: begin
          cnt_d = '0;
          if (tx_done) begin
            set_tx_done = 1'b1;
            state_d = (ctrl_q[CTRL_AUTO_RX] && ctrl_q[CTRL_RX_EN]) ? ST_IFS_WAIT : ST_IDLE;
          end
        end
        ST_IFS_WAIT: begin
          if (cnt_q == TMO_W'(IFS_CYCLES - 1)) begin
            state_d    = ST_RX_RUN;
            rx_start_d = 1'b1;
            cnt_d      = '0;
          end
        end
        ST_RX_RUN: begin
          if (rx_pkt_done) begin
            pkt_latch   = 1'b1;
            set_rx_done = 1'b1;
            state_d     = ST_IDLE;
          end else if ((rx_tmo_q != '0) && (cnt_q == rx_tmo_q - TMO_W'(1))) begin
            set_tmo = 1'b1;
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Interrupt status: set beats a same-cycle W1C clear
  always_comb begin
    irq_set = '0;
    irq_set[IRQ_TX_DONE] = set_tx_done;
    irq_set[IRQ_RX_DONE] = set_rx_done;
    irq_set[IRQ_TMO]     = set_tmo;
    irq_set[IRQ_RX_OVF]  = rx_push & rxf_full;
    irq_clr    = (wr_acc && (address == ADDR_W'(A_IRQ_STAT))) ? wdata[IRQ_W-1:0] : '0;
    irq_stat_d = (irq_stat_q & ~irq_clr) | irq_set;
    irq_mask_d = (wr_acc && (address == ADDR_W'(A_IRQ_MASK))) ? wdata[IRQ_W-1:0] : irq_mask_q;
  end

  // Read data mux; write-only registers read as zero
  always_comb begin
    case (address)
      ADDR_W'(A_CTRL):     rd_mux_c = 32'(ctrl_q);
      ADDR_W'(A_CMD):      rd_mux_c = '0;
      ADDR_W'(A_STATUS):   rd_mux_c = 32'({state_q, txf_cnt, rxf_cnt, txf_full, txf_empty,
                                           rxf_empty, crc_q, aa_found_q});
      ADDR_W'(A_IRQ_STAT): rd_mux_c = 32'(irq_stat_q);
      ADDR_W'(A_IRQ_MASK): rd_mux_c = 32'(irq_mask_q);
      ADDR_W'(A_TX_DATA):  rd_mux_c = '0;
      ADDR_W'(A_RX_DATA):  rd_mux_c = rxf_empty ? 32'h0 : 32'(rxf_data);
      ADDR_W'(A_AA):       rd_mux_c = aa;
      ADDR_W'(A_CH_IDX):   rd_mux_c = 32'(ch_idx);
      ADDR_W'(A_RX_TMO):   rd_mux_c = 32'(rx_tmo_q);
      default:             rd_mux_c = 32'hFFFF_FFFF;
    endcase
  end

  // CPU-visible registers and bus response
  always_ff @(posedge clk) begin
    if (rst) begin
      ready      <= 1'b0;
      rdata      <= '0;
      ctrl_q     <= '0;
      irq_stat_q <= '0;
      irq_mask_q <= '0;
      rx_tmo_q   <= '0;
      crc_q      <= 1'b0;
      aa_found_q <= 1'b0;
      aa         <= AA_RST;
      ch_idx     <= CH_IDX_W'(5);
      irq        <= 1'b0;
    end else begin
      ready      <= acc;
      irq_stat_q <= irq_stat_d;
      irq_mask_q <= irq_mask_d;
      irq        <= |(irq_stat_d & irq_mask_d);
      if (rd_acc) rdata <= rd_mux_c;
      if (wr_acc) begin
        case (address)
          ADDR_W'(A_CTRL):   ctrl_q   <= wdata[CTRL_W-1:0];
          ADDR_W'(A_AA):     aa       <= wdata;
          ADDR_W'(A_CH_IDX): ch_idx   <= wdata[CH_IDX_W-1:0];
          ADDR_W'(A_RX_TMO): rx_tmo_q <= wdata[TMO_W-1:0];
          default: ;
        endcase
      end
      if (pkt_latch) begin
        crc_q      <= rx_crc_valid;
        aa_found_q <= rx_aa_found;
      end
    end
  end

endmodule

// File: tb/tb_txrx_seq.sv
module tb_txrx_seq;

  localparam int unsigned IFS  = 150;
  localparam logic [31:0] AA_R = 32'h8E89BED6;

  logic        clk, rst, valid, wstrb;
  logic [3:0]  address;
  logic [31:0] wdata, rdata;
  logic        ready;
  logic [7:0]  tx_byte;
  logic        tx_byte_valid, tx_byte_ready, tx_start, tx_en, tx_done;
  logic [7:0]  rx_byte;
  logic        rx_byte_valid, rx_start, rx_en, rx_pkt_done, rx_crc_valid, rx_aa_found;
  logic [31:0] aa;
  logic [5:0]  ch_idx;
  logic        irq;

  txrx_seq #(.ADDR_W(4), .FIFO_AW(5), .CH_IDX_W(6), .IFS_CYCLES(IFS), .AA_RST(AA_R)) dut (
    .clk(clk), .rst(rst), .valid(valid), .address(address), .wdata(wdata), .wstrb(wstrb),
    .rdata(rdata), .ready(ready), .tx_byte(tx_byte), .tx_byte_valid(tx_byte_valid),
    .tx_byte_ready(tx_byte_ready), .tx_start(tx_start), .tx_en(tx_en), .tx_done(tx_done),
    .rx_byte(rx_byte), .rx_byte_valid(rx_byte_valid), .rx_start(rx_start), .rx_en(rx_en),
    .rx_pkt_done(rx_pkt_done), .rx_crc_valid(rx_crc_valid), .rx_aa_found(rx_aa_found),
    .aa(aa), .ch_idx(ch_idx), .irq(irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int pass_cnt = 0;
  int chk_cnt  = 0;
  int cyc = 0;
  int tx_done_cyc = 0, rx_start_cyc = 0;
  int tx_start_cnt = 0, rx_start_cnt = 0;
  logic [7:0] tx_got[$];
  bit rdy_rand = 1'b0;

  // Cycle stamps and TX byte capture
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (tx_done) tx_done_cyc <= cyc;
    if (rx_start) begin
      rx_start_cyc <= cyc;
      rx_start_cnt <= rx_start_cnt + 1;
    end
    if (tx_start) tx_start_cnt <= tx_start_cnt + 1;
    if (tx_byte_valid && tx_byte_ready) tx_got.push_back(tx_byte);
  end

  always @(negedge clk) tx_byte_ready <= rdy_rand ? 1'($urandom_range(0, 1)) : 1'b0;

  task automatic cpu_access(input logic we, input logic [3:0] a, input logic [31:0] d,
                            output logic [31:0] q);
    int n;
    valid = 1'b1; wstrb = we; address = a; wdata = d;
    n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (!ready && n < 8);
    if (!ready) begin
      chk_cnt++;
      $display("FAIL bus_ready addr=%0d got ready=%b exp 1", a, ready);
    end
    q = rdata;
    valid = 1'b0; wstrb = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    logic [31:0] q;
    cpu_access(1'b1, a, d, q);
  endtask

  task automatic rd(input logic [3:0] a, output logic [31:0] q);
    cpu_access(1'b0, a, 32'h0, q);
  endtask

  task automatic pulse_tx_done();
    tx_done = 1'b1; @(posedge clk); #1; tx_done = 1'b0;
  endtask

  task automatic wait_tx_bytes(input int n_exp);
    int n = 0;
    while (tx_got.size() < n_exp && n < 400) begin @(posedge clk); #1; n++; end
  endtask

  task automatic inject_rx(input logic [7:0] b);
    rx_byte = b; rx_byte_valid = 1'b1; @(posedge clk); #1; rx_byte_valid = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] q;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk_cnt++;
    if ({ready, tx_start, rx_start, tx_en, rx_en, tx_byte_valid, irq} !== 7'b0)
      $display("FAIL reset_ctl got %b exp 0000000", {ready, tx_start, rx_start, tx_en, rx_en, tx_byte_valid, irq});
    else pass_cnt++;
    chk_cnt++;
    if (rdata !== 32'h0) $display("FAIL reset_rdata got %h exp 0", rdata); else pass_cnt++;
    chk_cnt++;
    if (aa !== AA_R || ch_idx !== 6'd5) $display("FAIL reset_cfg got %h/%0d exp %h/5", aa, ch_idx, AA_R);
    else pass_cnt++;
    rst = 1'b0;
    @(posedge clk); #1;
    rd(4'd2, q);
    chk_cnt++;
    if (q !== 32'h0000000C) $display("FAIL reset_status got %h exp 0000000c", q); else pass_cnt++;
  endtask

  task automatic test_tx();
    logic [31:0] q;
    logic [7:0] exp_b[4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    for (int i = 0; i < 4; i++) wr(4'd5, 32'(exp_b[i]));
    rd(4'd2, q);
    chk_cnt++;
    if (q !== 32'h00002004) $display("FAIL tx_status4 got %h exp 00002004", q); else pass_cnt++;
    wr(4'd0, 32'h1);
    chk_cnt++;
    if (tx_en !== 1'b1) $display("FAIL tx_en got %b exp 1", tx_en); else pass_cnt++;
    tx_got.delete();
    rdy_rand = 1'b1;
    wr(4'd1, 32'h1);
    wait_tx_bytes(4);
    chk_cnt++;
    if (tx_got.size() != 4) $display("FAIL tx_count got %0d exp 4", tx_got.size()); else pass_cnt++;
    for (int i = 0; i < 4 && i < tx_got.size(); i++) begin
      chk_cnt++;
      if (tx_got[i] !== exp_b[i]) $display("FAIL tx_byte%0d got %h exp %h", i, tx_got[i], exp_b[i]);
      else pass_cnt++;
    end
    chk_cnt++;
    if (tx_start_cnt != 1) $display("FAIL tx_start_pulses got %0d exp 1", tx_start_cnt); else pass_cnt++;
    pulse_tx_done();
    rd(4'd3, q);
    chk_cnt++;
    if (q !== 32'h1) $display("FAIL tx_irq_stat got %h exp 1", q); else pass_cnt++;
    chk_cnt++;
    if (irq !== 1'b0) $display("FAIL irq_masked got %b exp 0", irq); else pass_cnt++;
    wr(4'd4, 32'h1);
    chk_cnt++;
    if (irq !== 1'b1) $display("FAIL irq_unmasked got %b exp 1", irq); else pass_cnt++;
    wr(4'd3, 32'h1);
    chk_cnt++;
    if (irq !== 1'b0) $display("FAIL irq_w1c got %b exp 0", irq); else pass_cnt++;
  endtask

  task automatic test_auto_rx();
    logic [31:0] q;
    int n;
    int rs0;
    logic [7:0] rx_b[4] = '{8'hA1, 8'hB2, 8'hC3, 8'h00};
    wr(4'd0, 32'h7);
    wr(4'd5, 32'h5A);
    tx_got.delete();
    rs0 = rx_start_cnt;
    wr(4'd1, 32'h1);
    wait_tx_bytes(1);
    pulse_tx_done();
    n = 0;
    while (rx_start_cnt == rs0 && n < 400) begin @(posedge clk); #1; n++; end
    chk_cnt++;
    if (rx_start_cyc - tx_done_cyc != int'(IFS) + 1)
      $display("FAIL ifs_latency got %0d exp %0d", rx_start_cyc - tx_done_cyc, IFS + 1);
    else pass_cnt++;
    chk_cnt++;
    if (rx_start_cnt != rs0 + 1) $display("FAIL rx_start_pulses got %0d exp %0d", rx_start_cnt, rs0 + 1);
    else pass_cnt++;
    for (int i = 0; i < 3; i++) inject_rx(rx_b[i]);
    rx_crc_valid = 1'b1; rx_aa_found = 1'b1; rx_pkt_done = 1'b1;
    @(posedge clk); #1;
    rx_crc_valid = 1'b0; rx_aa_found = 1'b0; rx_pkt_done = 1'b0;
    rd(4'd3, q);
    chk_cnt++;
    if (q !== 32'h3) $display("FAIL auto_irq_stat got %h exp 3", q); else pass_cnt++;
    rd(4'd2, q);
    chk_cnt++;
    if (q !== 32'h0000006B) $display("FAIL auto_status got %h exp 0000006b", q); else pass_cnt++;
    for (int i = 0; i < 4; i++) begin
      rd(4'd6, q);
      chk_cnt++;
      if (q !== 32'(rx_b[i])) $display("FAIL rx_pop%0d got %h exp %h", i, q, 32'(rx_b[i]));
      else pass_cnt++;
    end
    wr(4'd3, 32'hF);
  endtask

  task automatic test_timeout();
    logic [31:0] q;
    wr(4'd9, 32'd100);
    wr(4'd0, 32'h2);
    wr(4'd1, 32'h2);
    wr(4'd0, 32'h0);
    repeat (96) @(posedge clk);
    #1;
    chk_cnt++;
    if (rx_en !== 1'b1) $display("FAIL tmo_still_rx got %b exp 1", rx_en); else pass_cnt++;
    @(posedge clk); #1;
    chk_cnt++;
    if (rx_en !== 1'b0) $display("FAIL tmo_idle got %b exp 0", rx_en); else pass_cnt++;
    rd(4'd3, q);
    chk_cnt++;
    if (q !== 32'h4) $display("FAIL tmo_irq got %h exp 4", q); else pass_cnt++;
    wr(4'd3, 32'h4);
    rd(4'd3, q);
    chk_cnt++;
    if (q !== 32'h0) $display("FAIL tmo_w1c got %h exp 0", q); else pass_cnt++;
  endtask

  task automatic test_overflow();
    logic [31:0] q;
    wr(4'd9, 32'd0);
    wr(4'd0, 32'h2);
    wr(4'd1, 32'h2);
    for (int i = 0; i < 33; i++) inject_rx(8'(i + 1));
    rx_pkt_done = 1'b1; @(posedge clk); #1; rx_pkt_done = 1'b0;
    rd(4'd3, q);
    chk_cnt++;
    if (q !== 32'hA) $display("FAIL ovf_irq got %h exp a", q); else pass_cnt++;
    rd(4'd2, q);
    chk_cnt++;
    if (q !== 32'h00000408) $display("FAIL rxf_full_status got %h exp 00000408", q); else pass_cnt++;
    rd(4'd6, q);
    chk_cnt++;
    if (q !== 32'h1) $display("FAIL ovf_head got %h exp 1", q); else pass_cnt++;
    wr(4'd1, 32'h8);
    rd(4'd2, q);
    chk_cnt++;
    if (q !== 32'h0000000C) $display("FAIL flush_status got %h exp 0000000c", q); else pass_cnt++;
    for (int i = 0; i < 33; i++) wr(4'd5, 32'(i));
    rd(4'd2, q);
    chk_cnt++;
    if (q !== 32'h00010014) $display("FAIL txf_full_status got %h exp 00010014", q); else pass_cnt++;
    wr(4'd1, 32'h8);
    wr(4'd3, 32'hF);
  endtask

  task automatic test_abort();
    logic [31:0] q;
    int rs0;
    wr(4'd0, 32'h7);
    wr(4'd5, 32'h77);
    tx_got.delete();
    wr(4'd1, 32'h1);
    wait_tx_bytes(1);
    pulse_tx_done();
    repeat (20) @(posedge clk);
    #1;
    wr(4'd1, 32'h4);
    rs0 = rx_start_cnt;
    repeat (200) @(posedge clk);
    #1;
    chk_cnt++;
    if (rx_start_cnt != rs0) $display("FAIL abort_no_rx_start got %0d exp %0d", rx_start_cnt, rs0);
    else pass_cnt++;
    rd(4'd2, q);
    chk_cnt++;
    if (q !== 32'h0000000C) $display("FAIL abort_status got %h exp 0000000c", q); else pass_cnt++;
    wr(4'd3, 32'hF);
  endtask

  task automatic test_regs();
    logic [31:0] q;
    rd(4'd15, q);
    chk_cnt++;
    if (q !== 32'hFFFFFFFF) $display("FAIL unmapped_rd got %h exp ffffffff", q); else pass_cnt++;
    wr(4'd7, 32'h12345678);
    chk_cnt++;
    if (aa !== 32'h12345678) $display("FAIL aa_out got %h exp 12345678", aa); else pass_cnt++;
    wr(4'd8, 32'h2A);
    chk_cnt++;
    if (ch_idx !== 6'h2A) $display("FAIL ch_idx_out got %h exp 2a", ch_idx); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    logic [31:0] q;
    rdy_rand = 1'b0;
    wr(4'd0, 32'h1);
    wr(4'd5, 32'hAB);
    wr(4'd5, 32'hCD);
    wr(4'd1, 32'h1);
    chk_cnt++;
    if (tx_byte_valid !== 1'b1 || tx_byte !== 8'hAB)
      $display("FAIL txrun_head got %b/%h exp 1/ab", tx_byte_valid, tx_byte);
    else pass_cnt++;
    rst = 1'b1;
    @(posedge clk); #1;
    chk_cnt++;
    if ({tx_byte_valid, tx_en, rx_en, irq, ready} !== 5'b0)
      $display("FAIL midrst_ctl got %b exp 00000", {tx_byte_valid, tx_en, rx_en, irq, ready});
    else pass_cnt++;
    chk_cnt++;
    if (aa !== AA_R || ch_idx !== 6'd5) $display("FAIL midrst_cfg got %h/%0d exp %h/5", aa, ch_idx, AA_R);
    else pass_cnt++;
    rst = 1'b0;
    rd(4'd2, q);
    chk_cnt++;
    if (q !== 32'h0000000C) $display("FAIL midrst_status got %h exp 0000000c", q); else pass_cnt++;
    rd(4'd4, q);
    chk_cnt++;
    if (q !== 32'h0) $display("FAIL midrst_mask got %h exp 0", q); else pass_cnt++;
  endtask

  initial begin
    rst = 1'b1; valid = 1'b0; wstrb = 1'b0; address = '0; wdata = '0;
    tx_done = 1'b0; rx_byte = '0; rx_byte_valid = 1'b0;
    rx_pkt_done = 1'b0; rx_crc_valid = 1'b0; rx_aa_found = 1'b0;
    tx_byte_ready = 1'b0;
    test_reset();
    test_tx();
    test_auto_rx();
    test_timeout();
    test_overflow();
    test_abort();
    test_regs();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
